fixed_point_divider: RTL

- Sequential signed fixed-point divider that computes Div_result = a / b, the inverse operation of the fixed-point multiplier in the datapath.
- Uses the same Q format as the multiplier: `bitsize` total bits, `FRAC_BITS` fractional bits, two's complement.
- Restoring radix-2 algorithm, one quotient bit per clock, operating on magnitudes.
- Output is rounded to nearest, ties to even, then saturated. It uses the same start_flag/valid handshake as the multiplier, so it drops into normalisation and scaling paths.

---
 rtl/fixed_point_divider.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider: restoring radix-2 on magnitudes,
// one quotient bit per clock, round-to-nearest-even, saturated result.
module fixed_point_divider #(
    parameter int bitsize   = 14,
    parameter int FRAC_BITS = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_flag,
    input  logic [bitsize-1:0] a,
    input  logic [bitsize-1:0] b,
    output logic [bitsize-1:0] Div_result,
    output logic               valid,
    output logic               busy,
    output logic               div_by_zero
);
    localparam int ITER = bitsize + FRAC_BITS + 1;
    localparam int CW   = $clog2(ITER + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIVIDE = 2'd1;
    localparam logic [1:0] ROUND  = 2'd2;

    localparam logic [bitsize-1:0] MAX_POS = {1'b0, {(bitsize-1){1'b1}}};
    localparam logic [bitsize-1:0] MIN_NEG = {1'b1, {(bitsize-1){1'b0}}};
    localparam logic [ITER-1:0]    MAG_MAX_POS = {{(ITER-bitsize){1'b0}}, MAX_POS};
    localparam logic [ITER-1:0]    MAG_MAX_NEG = {{(ITER-bitsize){1'b0}}, MIN_NEG};
    localparam logic [CW-1:0]      CNT_LOAD = CW'(ITER - 1);

    logic [1:0]         state_reg;
    logic [CW-1:0]      cnt_reg;
    logic [ITER-1:0]    n_reg;
    logic [ITER-1:0]    q_reg;
    logic [bitsize:0]   rem_reg;
    logic [bitsize-1:0] divisor_reg;
    logic               sign_reg;
    logic               zero_reg;

    logic [bitsize-1:0] a_mag;
    logic [bitsize-1:0] b_mag;
    logic [bitsize:0]   rem_shift;
    logic               rem_ge;
    logic [bitsize:0]   rem_next;
    logic [ITER-2:0]    base;
    logic               round_up;
    logic [ITER-1:0]    mag;
    logic [bitsize-1:0] result_next;

    // Negating the most negative value wraps to 2^(bitsize-1), which is exact as unsigned.
    assign a_mag = a[bitsize-1] ? (~a + 1'b1) : a;
    assign b_mag = b[bitsize-1] ? (~b + 1'b1) : b;

    assign rem_shift = {rem_reg[bitsize-1:0], n_reg[ITER-1]};
    assign rem_ge    = rem_shift >= {1'b0, divisor_reg};
    assign rem_next  = rem_ge ? (rem_shift - {1'b0, divisor_reg}) : rem_shift;

    // Q carries one extra fractional bit, used as the guard bit for rounding.
    assign base     = q_reg[ITER-1:1];
    assign round_up = q_reg[0] & ((|rem_reg) | base[0]);
    assign mag      = {1'b0, base} + {{(ITER-1){1'b0}}, round_up};

    always_comb begin
        result_next = '0;
        if (zero_reg) begin
            result_next = sign_reg ? MIN_NEG : MAX_POS;
        end else if (!sign_reg && (mag > MAG_MAX_POS)) begin
            result_next = MAX_POS;
        end else if (sign_reg && (mag > MAG_MAX_NEG)) begin
            result_next = MIN_NEG;
        end else if (sign_reg) begin
            result_next = ~mag[bitsize-1:0] + 1'b1;
        end else begin
            result_next = mag[bitsize-1:0];
        end
    end

    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            n_reg       <= '0;
            q_reg       <= '0;
            rem_reg     <= '0;
            divisor_reg <= '0;
            sign_reg    <= 1'b0;
            zero_reg    <= 1'b0;
            Div_result  <= '0;
            valid       <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_flag) begin
                        n_reg       <= {a_mag, {(FRAC_BITS+1){1'b0}}};
                        q_reg       <= '0;
                        rem_reg     <= '0;
                        divisor_reg <= b_mag;
                        sign_reg    <= a[bitsize-1] ^ b[bitsize-1];
                        zero_reg    <= (b == '0);
                        cnt_reg     <= CNT_LOAD;
                        state_reg   <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem_reg <= rem_next;
                    q_reg   <= {q_reg[ITER-2:0], rem_ge};
                    n_reg   <= {n_reg[ITER-2:0], 1'b0};
                    if (cnt_reg == '0) begin
                        state_reg <= ROUND;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ROUND: begin
                    Div_result  <= result_next;
                    div_by_zero <= zero_reg;
                    valid       <= 1'b1;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
